// File: rtl/program_loader.sv
// Program loader: receives a program over the debug UART byte stream and
// writes it, one assembled word at a time, into instruction RAM. A command
// byte starts the load; the HALT word (or a full memory) ends it and raises
// a sticky done flag that releases instruction fetch.
module program_loader #(
    parameter int                len       = 32,
    parameter int                ADDR_LEN  = 11,
    parameter logic [7:0]        CMD_LOAD  = 8'h4C,
    parameter logic [len-1:0]    HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_rx_data,
    input  logic                in_rx_done,
    output logic                out_wr_en,
    output logic [ADDR_LEN-1:0] out_wr_addr,
    output logic [len-1:0]      out_wr_data,
    output logic                out_load_done,
    output logic [ADDR_LEN:0]   out_word_count,
    output logic                out_overflow,
    output logic                out_overrun
);

    localparam int BYTES = len / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [len-1:0]      shift_q,      shift_d;
    logic [CNT_W-1:0]    byte_cnt_q,   byte_cnt_d;
    logic [ADDR_LEN-1:0] addr_q,       addr_d;
    logic [ADDR_LEN-1:0] wr_addr_q,    wr_addr_d;
    logic [len-1:0]      wr_data_q,    wr_data_d;
    logic [ADDR_LEN:0]   word_count_q, word_count_d;
    logic                load_done_q,  load_done_d;
    logic                overflow_q,   overflow_d;
    logic                overrun_q,    overrun_d;

    // State register and all datapath registers, synchronous reset.
    // RAM contents live outside this block and are deliberately untouched.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of the others, independent of statement order.
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic: byte assembly, write sequencing and termination.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        overflow_d   = overflow_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (in_rx_done && in_rx_data == CMD_LOAD) begin
                    state_d      = RECV;
                    byte_cnt_d   = '0;
                    addr_d       = '0;
                    word_count_d = '0;
                end
            end

            RECV: begin
                if (in_rx_done) begin
                    // Big-endian: earlier bytes end up in the upper bits.
                    shift_d = (shift_q << 8) | len'(in_rx_data);
                    if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        wr_data_d  = shift_d;
                        wr_addr_d  = addr_q;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            WRITE: begin
                word_count_d = word_count_q + 1'b1;
                // No receive buffer: a byte landing on the write cycle is lost.
                if (in_rx_done) begin
                    overrun_d = 1'b1;
                end
                if (wr_data_q == HALT_WORD) begin
                    state_d     = DONE;
                    load_done_d = 1'b1;
                end else if (addr_q == '1) begin
                    // Last RAM word used without a HALT: stop rather than wrap.
                    state_d     = DONE;
                    load_done_d = 1'b1;
                    overflow_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RECV;
                end
            end

            DONE: begin
                // Terminal until reset; every received byte is ignored.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The write strobe is exactly the single WRITE cycle.
    assign out_wr_en      = (state_q == WRITE);
    assign out_wr_addr    = wr_addr_q;
    assign out_wr_data    = wr_data_q;
    assign out_load_done  = load_done_q;
    assign out_word_count = word_count_q;
    assign out_overflow   = overflow_q;
    assign out_overrun    = overrun_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory: fills instruction RAM with a program received byte-by-byte from the UART receiver in the debug unit.
- Assembles bytes into 32-bit words and issues one-cycle write strobes at consecutive word addresses.
- Detects the HALT word, then raises a sticky done flag that releases the pipeline (fetch enable).
- Sits between uart_rx and the instruction RAM write port, in parallel with the fetch-side read port.

Parameters:
- len, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_LEN, 11, word address width (RAM depth 2^ADDR_LEN = 2048).
- CMD_LOAD, 8'h4C, command byte that starts a load.
- HALT_WORD, 32'hFFFFFFFF, end-of-program instruction.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_rx_data  in  8  byte from UART receiver; valid only while in_rx_done=1.
- in_rx_done  in  1  one-cycle strobe, new byte present.
- out_wr_en  out  1  instruction RAM write strobe, one cycle per word.
- out_wr_addr  out  ADDR_LEN  word address for the write.
- out_wr_data  out  len  assembled instruction word.
- out_load_done  out  1  sticky; program loaded, CPU may run.
- out_word_count  out  ADDR_LEN+1  number of words written, including HALT.
- out_overflow  out  1  sticky; memory filled with no HALT received.
- out_overrun  out  1  sticky; byte arrived while in WRITE and was dropped.

Behaviour:
- Reset (synchronous, active-high) values:
  - All outputs 0; state=IDLE; byte_cnt=0; address=0.
  - reset asserted mid-load abandons the partial word.
  - RAM contents already written are not cleared.
- State IDLE:
  - in_rx_done with in_rx_data==CMD_LOAD → RECV, clear byte_cnt, address and out_word_count.
  - Any other byte is ignored.
- State RECV:
  - Each in_rx_done shifts the byte into a shift register, big-endian: first byte received = bits [len-1:len-8].
  - byte_cnt counts 0..len/8-1.
  - On the strobe carrying the last byte: latch the full word into out_wr_data, the address into out_wr_addr, set out_wr_en=1 on the next cycle, → WRITE.
  - Latency: last-byte in_rx_done at cycle N → out_wr_en=1 at cycle N+1, exactly one cycle wide.
- State WRITE (one cycle):
  - out_wr_en=1; out_word_count increments at the end of the cycle.
  - If out_wr_data==HALT_WORD → DONE.
  - Else if address==2^ADDR_LEN-1 → DONE with out_overflow=1.
  - Else address+1 → RECV.
  - in_rx_done during WRITE: byte dropped, out_overrun=1 (sticky), state transition unaffected.
- State DONE:
  - out_load_done=1 from the cycle after the final write; out_wr_en=0.
  - All in_rx_done ignored, including CMD_LOAD; only reset leaves DONE.
- Address arithmetic:
  - Unsigned, ADDR_LEN bits; never wraps (overflow terminates the load instead).
  - out_word_count holds up to 2^ADDR_LEN.
- out_wr_addr and out_wr_data hold their last values outside WRITE; the RAM samples them only when out_wr_en=1.
- HALT word is itself written to memory so fetch sees it and stalls.

Test Plan:
- Reset: reset=1 for 2 cycles, rx idle → all outputs 0, no out_wr_en; bytes 0x12,0x34 sent before CMD_LOAD → ignored, no write.
- Normal load: CMD 0x4C, then bytes 20 01 00 05 | FF FF FF FF → two writes:
  - addr0 = 0x20010005.
  - addr1 = 0xFFFFFFFF.
  - out_wr_en exactly 1 cycle after each 4th rx_done.
  - out_load_done=1 one cycle after the second write; out_word_count=2.
- Post-done: after DONE, send 0x4C and 4 bytes → no out_wr_en, outputs unchanged.
- Reset mid-word: CMD, bytes AA BB, reset for 1 cycle, then CMD, 11 22 33 44, FF×4 → addr0=0x11223344, addr1=HALT, no 0xAABB… write.
- Overflow: ADDR_LEN=2 instance, CMD then 4 non-HALT words → writes at addr 0..3, then out_overflow=1, out_load_done=1, out_word_count=4.
- Overrun: assert in_rx_done in the WRITE cycle (back-to-back with the 4th byte) → out_overrun=1, byte discarded, next word assembled from subsequent bytes only.
